uart_reg_arbiter: RTL

Two-requester arbiter for the UART register-file access port: the rwaddr field, rd/wr strobes, write byte and read byte.
- Port 0 is the host-side command path.
- Port 1 is the on-chip bus bridge.
Each port's request is latched into a slot. One access at a time is issued to the register file under round-robin order. Read data is returned to the originating port after a fixed register-file latency. The block also generates the RX-FIFO fetch strobe when a read hits the data-out register.

---
 rtl/uart_pkg.sv | 15 +
 rtl/reg_req_slot.sv | 42 ++++
 rtl/uart_reg_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART register-file types: address width, data-out register offset and
// the request record held by the arbiter slots.
package uart_pkg;

    typedef logic [2:0] reg_rwaddr;

    localparam reg_rwaddr UART_DOUTL_OFFSET = 3'd0;

    typedef struct packed {
        logic      we;
        reg_rwaddr addr;
        logic [7:0] wdata;
    } reg_access_t;

endpackage

// File: rtl/reg_req_slot.sv
// Single-entry request holder: captures a request when empty, flags a dropped
// request when full, and empties on the owner's completion pulse.
module reg_req_slot
    import uart_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  reg_access_t i_access,
    input  logic        i_clear,
    output logic        o_valid,
    output reg_access_t o_access,
    output logic        o_overrun
);

    logic        valid_reg;
    reg_access_t access_reg;
    logic        overrun_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_reg   <= 1'b0;
            access_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            // A request landing while the slot is still occupied (including the
            // freeing cycle) is dropped and reported.
            overrun_reg <= i_req & valid_reg;
            if (i_req && !valid_reg) begin
                valid_reg  <= 1'b1;
                access_reg <= i_access;
            end else if (i_clear) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign o_valid   = valid_reg;
    assign o_access  = access_reg;
    assign o_overrun = overrun_reg;

endmodule

// File: rtl/uart_reg_arbiter.sv
// Round-robin arbiter giving two requesters one-at-a-time access to the UART
// register file, returning read data to the originating port.
module uart_reg_arbiter
    import uart_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_we,
    input  reg_rwaddr [1:0]       i_addr,
    input  logic [1:0][7:0]       i_wdata,
    output logic [1:0]            o_ready,
    output logic [1:0]            o_overrun,
    output logic [1:0]            o_wdone,
    output logic [1:0]            o_rvalid,
    output logic [7:0]            o_rdata,
    output logic                  o_rd_req,
    output logic                  o_wr_req,
    output reg_rwaddr             o_rwaddr,
    output logic [7:0]            o_write_reg,
    output logic                  o_fifo_fetch,
    input  logic [7:0]            i_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;
    localparam logic [1:0] RETURN  = 2'd3;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

    logic [1:0]  slot_valid;
    reg_access_t slot_access [2];
    reg_access_t req_access  [2];

    logic [1:0] state_reg;
    logic       grant_reg;
    logic       ptr_reg;
    logic [2:0] cnt_reg;
    logic [1:0] wdone_reg;
    logic [1:0] rvalid_reg;
    logic [7:0] rdata_reg;
    logic       rd_req_reg;
    logic       wr_req_reg;
    logic       fifo_fetch_reg;
    reg_rwaddr  rwaddr_reg;
    logic [7:0] write_reg_reg;

    // A slot whose completion pulse is showing is still occupied but already served.
    logic [1:0] completing;
    logic [1:0] eligible;
    logic       grant_next;

    assign completing = wdone_reg | rvalid_reg;
    assign eligible   = slot_valid & ~completing;
    assign grant_next = (eligible == 2'b11) ? ptr_reg : eligible[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        assign req_access[gi] = '{we: i_we[gi], addr: i_addr[gi], wdata: i_wdata[gi]};

        reg_req_slot u_slot (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_req     (i_req[gi]),
            .i_access  (req_access[gi]),
            .i_clear   (completing[gi]),
            .o_valid   (slot_valid[gi]),
            .o_access  (slot_access[gi]),
            .o_overrun (o_overrun[gi])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            ptr_reg        <= 1'b0;
            cnt_reg        <= 3'd0;
            wdone_reg      <= 2'b00;
            rvalid_reg     <= 2'b00;
            rdata_reg      <= 8'h00;
            rd_req_reg     <= 1'b0;
            wr_req_reg     <= 1'b0;
            fifo_fetch_reg <= 1'b0;
            rwaddr_reg     <= '0;
            write_reg_reg  <= 8'h00;
        end else begin
            rd_req_reg     <= 1'b0;
            wr_req_reg     <= 1'b0;
            fifo_fetch_reg <= 1'b0;
            wdone_reg      <= 2'b00;
            rvalid_reg     <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (|eligible) begin
                        grant_reg  <= grant_next;
                        state_reg  <= ISSUE;
                        cnt_reg    <= LAT_LOAD;
                        rwaddr_reg <= slot_access[grant_next].addr;
                        if (slot_access[grant_next].we) begin
                            wr_req_reg    <= 1'b1;
                            write_reg_reg <= slot_access[grant_next].wdata;
                        end else begin
                            rd_req_reg     <= 1'b1;
                            write_reg_reg  <= 8'h00;
                            fifo_fetch_reg <= (slot_access[grant_next].addr == UART_DOUTL_OFFSET);
                        end
                    end
                end
                ISSUE, WAIT_RD: begin
                    if (state_reg == ISSUE && slot_access[grant_reg].we) begin
                        wdone_reg[grant_reg] <= 1'b1;
                        ptr_reg              <= ~grant_reg;
                        state_reg            <= IDLE;
                    end else if (cnt_reg == 3'd0) begin
                        // i_rdata is taken in the last cycle before RETURN so the
                        // result is presented READ_LAT cycles after the read strobe.
                        rdata_reg             <= i_rdata;
                        rvalid_reg[grant_reg] <= 1'b1;
                        state_reg             <= RETURN;
                    end else begin
                        cnt_reg   <= cnt_reg - 3'd1;
                        state_reg <= WAIT_RD;
                    end
                end
                default: begin
                    ptr_reg   <= ~grant_reg;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_ready      = ~slot_valid;
    assign o_wdone      = wdone_reg;
    assign o_rvalid     = rvalid_reg;
    assign o_rdata      = rdata_reg;
    assign o_rd_req     = rd_req_reg;
    assign o_wr_req     = wr_req_reg;
    assign o_rwaddr     = rwaddr_reg;
    assign o_write_reg  = write_reg_reg;
    assign o_fifo_fetch = fifo_fetch_reg;

endmodule
